key_schedule_gen: RTL and testbench
===================================

Name: key_schedule_gen

Overview:
- Iterative AES key schedule generator, parametrised for AES-128 and AES-256.
- Accepts a cipher key on a start pulse and expands one 32-bit schedule word per clock into an internal word buffer.
- After expansion, serves any round key by index with a registered read port.
- Sits between key load logic and the round datapath, replacing the per-round combinational expander.

Parameters:
- KEY_BITS, 128, cipher key size. Legal values are 128 and 256. Derived values: NK = KEY_BITS/32, NR = NK+6, NW = 4*(NR+1) (44 or 60).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to expand key_in
- key_in  input  KEY_BITS  cipher key, FIPS-197 byte order; MSB word is w[0]
- busy  output  1  expansion in progress
- done  output  1  schedule valid; level signal
- rd_en  input  1  round-key read strobe
- rd_round  input  4  round index 0..NR
- rd_inv  input  1  request the equivalent-inverse-cipher form (see Optional Feature)
- rd_key  output  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}
- rd_valid  output  1  rd_key holds a valid key this cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, rd_valid=0, rd_key=0; word index=0. Buffer contents are don't-care.
- States: IDLE, EXPAND, DONE.
- Start acceptance:
  - start is accepted in IDLE or DONE, i.e. only when busy=0.
  - On the accepting edge: w[0..NK-1] are loaded from key_in, index=NK, done=0, busy=1, state goes to EXPAND.
- EXPAND (one word per cycle at index i):
  - temp = w[i-1].
  - If i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/NK], 24'h0}.
  - Else if NK==8 and i mod 8 == 4: temp = SubWord(temp).
  - Write w[i] = w[i-NK] ^ temp, then i = i+1.
- Completion:
  - On the edge that writes w[NW-1], state goes to DONE, busy=0, done=1.
  - Busy duration: 40 cycles for 128-bit keys, 52 cycles for 256-bit keys.
- Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36, generated by an xtime shift register. It is reset on start, not stored as a table.
- SubWord uses four copies of an internal 256-entry forward S-box.
- Start while busy is ignored. The expansion continues undisturbed and no second run is queued.
- Start in DONE: done drops on the accepting edge and the old schedule is invalid from that edge on.
- Reads: the rd_en sample at edge T drives rd_key/rd_valid from edge T until the next edge (1-cycle latency).
  - rd_valid=1 only if done=1 at T and rd_round <= NR.
  - Otherwise rd_valid=0 and rd_key=0.
  - rd_en=0 gives rd_valid=0; rd_key holds its last value.
- Simultaneous start and rd_en in DONE: the read returns the old schedule and is valid. The new expansion begins on the same edge.
- Reset mid-EXPAND: everything returns to IDLE immediately, and done stays 0 until a full new expansion completes.

Optional Feature:
- Macro: KEY_SCHED_INV_EN.
- Defined:
  - rd_inv=1 applies InvMixColumns to each 32-bit column of rd_key for rounds 1..NR-1. This is the equivalent-inverse-cipher decryption key.
  - Rounds 0 and NR pass unchanged.
  - The transform is in the read path before the output register, so read latency stays 1 cycle.
- Not defined: the rd_inv port exists but is ignored, and rd_key is always the forward key.

Test Plan:
- AES-128: reset, start with key_in=2b7e151628aed2a6abf7158809cf4f3c -> busy for 40 cycles, then done=1. Read round 1 -> a0fafe1788542cb123a339392a6c7605. Read round 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6. Read round 0 -> the key itself.
- AES-256 (KEY_BITS=256): start with key_in=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> busy 52 cycles. Round 1 -> 1f352c073b6108d72d9810a30914dff4. Round 14 -> fe4890d1e6188d0b046df344706c631e.
- Out-of-range and early reads:
  - rd_round=11 on AES-128 -> rd_valid=0, rd_key=0.
  - Read during busy -> rd_valid=0.
  - Read before any start -> rd_valid=0.
- Start during busy: second start with a different key at cycle 10 of the expansion -> ignored. Round-10 result still equals the first key's value, and busy length is unchanged.
- Reset mid-EXPAND at cycle 20 -> busy=0 and done=0 asynchronously. A subsequent start completes normally with the FIPS values above.
- KEY_SCHED_INV_EN defined:
  - AES-128 read of rounds 0/10 with rd_inv=1 -> identical to forward keys.
  - Rounds 1..9 with rd_inv=1 -> match InvMixColumns of the forward key computed by the bench model.
  - Macro undefined: rd_inv=1 -> forward keys.

Source files
------------

// File: rtl/key_schedule_gen_if.sv
// Key schedule request/read bundle: start/key load, status, and round-key read port.
interface key_schedule_gen_if #(
  parameter int unsigned KEY_BITS = 128
) ();
  logic                start;
  logic [KEY_BITS-1:0] key_in;
  logic                busy;
  logic                done;
  logic                rd_en;
  logic [3:0]          rd_round;
  logic                rd_inv;
  logic [127:0]        rd_key;
  logic                rd_valid;

  modport master (
    output start, key_in, rd_en, rd_round, rd_inv,
    input  busy, done, rd_key, rd_valid
  );

  modport slave (
    input  start, key_in, rd_en, rd_round, rd_inv,
    output busy, done, rd_key, rd_valid
  );
endinterface

// File: rtl/key_schedule_gen.sv
// Iterative AES-128/256 key expansion (one word per clock) with a registered round-key read port.
// Optional KEY_SCHED_INV_EN: rd_inv returns equivalent-inverse-cipher round keys.
module key_schedule_gen #(
  parameter int unsigned KEY_BITS = 128
) (
  input logic               clk,
  input logic               rst_n,
  key_schedule_gen_if.slave bus
);
  localparam int unsigned NK    = KEY_BITS / 32;
  localparam int unsigned NR    = NK + 6;
  localparam int unsigned NW    = 4 * (NR + 1);
  localparam int unsigned IdxW  = $clog2(NW);
  localparam int unsigned NkLog = $clog2(NK);

  // Forward S-box; entry 0 sits in the most significant byte, so index with ~x.
  localparam logic [255:0][7:0] Sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return Sbox[~x];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

`ifdef KEY_SCHED_INV_EN
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] b [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      b[i]  = c[31-8*i -: 8];
      x2    = xtime(b[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ b[i];
      mb[i] = x8 ^ x2 ^ b[i];
      md[i] = x8 ^ x4 ^ b[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`endif

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [7:0]      rcon_q, rcon_d;
  logic            load, write_word;
  logic [31:0]     w_q [NW];
  logic [31:0]     temp, new_word;
  logic [NkLog-1:0] idx_mod;

  assign idx_mod = idx_q[NkLog-1:0];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rcon_d     = rcon_q;
    load       = 1'b0;
    write_word = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          load    = 1'b1;
          idx_d   = IdxW'(NK);
          rcon_d  = 8'h01;
          state_d = StExpand;
        end
      end
      StExpand: begin
        write_word = 1'b1;
        idx_d      = idx_q + IdxW'(1);
        if (idx_mod == '0) rcon_d = xtime(rcon_q);
        if (idx_q == IdxW'(NW - 1)) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    temp = w_q[idx_q - IdxW'(1)];
    if (idx_mod == '0) begin
      temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon_q, 24'h0};
    end else if ((NK == 8) && (idx_mod == NkLog'(NK / 2))) begin
      temp = sub_word(temp);
    end
    new_word = w_q[idx_q - IdxW'(NK)] ^ temp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
    end
  end

  // Schedule buffer carries no reset; its contents only matter once done is set.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int j = 0; j < NK; j++) begin
        w_q[j] <= bus.key_in[KEY_BITS-1-32*j -: 32];
      end
    end else if (write_word) begin
      w_q[idx_q] <= new_word;
    end
  end

  assign bus.busy = (state_q == StExpand);
  assign bus.done = (state_q == StDone);

  logic            rd_in_range;
  logic [3:0]      rd_sel;
  logic [IdxW-1:0] rd_base;
  logic [127:0]    rd_word_key, rd_key_q, rd_key_d;
  logic            rd_valid_q, rd_valid_d;

  // Out-of-range rounds are clamped to 0 so the buffer is never addressed past NW-1.
  assign rd_in_range = (bus.rd_round <= 4'(NR));
  assign rd_sel      = rd_in_range ? bus.rd_round : 4'd0;
  assign rd_base     = IdxW'({rd_sel, 2'b00});

  always_comb begin
    rd_word_key = {w_q[rd_base], w_q[rd_base + IdxW'(1)],
                   w_q[rd_base + IdxW'(2)], w_q[rd_base + IdxW'(3)]};
`ifdef KEY_SCHED_INV_EN
    if (bus.rd_inv && (rd_sel != 4'd0) && (rd_sel != 4'(NR))) begin
      rd_word_key = {inv_mix_col(rd_word_key[127:96]), inv_mix_col(rd_word_key[95:64]),
                     inv_mix_col(rd_word_key[63:32]), inv_mix_col(rd_word_key[31:0])};
    end
`endif
  end

`ifndef KEY_SCHED_INV_EN
  logic unused_rd_inv;
  assign unused_rd_inv = bus.rd_inv;
`endif

  always_comb begin
    rd_valid_d = 1'b0;
    rd_key_d   = rd_key_q;
    if (bus.rd_en) begin
      if ((state_q == StDone) && rd_in_range) begin
        rd_valid_d = 1'b1;
        rd_key_d   = rd_word_key;
      end else begin
        rd_key_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_key_q   <= rd_key_d;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_key   = rd_key_q;
endmodule

// File: tb/tb_key_schedule_gen.sv
// Self-checking bench: AES-128 and AES-256 instances against an arithmetic key-expansion model.
module tb_key_schedule_gen;
`ifdef KEY_SCHED_INV_EN
  localparam bit InvEn = 1'b1;
`else
  localparam bit InvEn = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         sel;
  logic         start_v;
  logic [255:0] key_v;
  logic         rd_en;
  logic [3:0]   rd_round;
  logic         rd_inv;

  key_schedule_gen_if #(.KEY_BITS(128)) bus_a ();
  key_schedule_gen_if #(.KEY_BITS(256)) bus_b ();

  assign bus_a.start    = start_v & ~sel;
  assign bus_a.key_in   = key_v[255:128];
  assign bus_a.rd_en    = rd_en;
  assign bus_a.rd_round = rd_round;
  assign bus_a.rd_inv   = rd_inv;
  assign bus_b.start    = start_v & sel;
  assign bus_b.key_in   = key_v;
  assign bus_b.rd_en    = rd_en;
  assign bus_b.rd_round = rd_round;
  assign bus_b.rd_inv   = rd_inv;

  key_schedule_gen #(.KEY_BITS(128)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  key_schedule_gen #(.KEY_BITS(256)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic         obs_busy, obs_done, obs_valid;
  logic [127:0] obs_key;
  assign obs_busy  = sel ? bus_b.busy : bus_a.busy;
  assign obs_done  = sel ? bus_b.done : bus_a.done;
  assign obs_valid = sel ? bus_b.rd_valid : bus_a.rd_valid;
  assign obs_key   = sel ? bus_b.rd_key : bus_a.rd_key;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_total = 0;
  int           n_bad = 0;
  int           nk, nr;
  logic [31:0]  m_w [64];
  logic [127:0] last_key;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
    end
    s = inv ^ 8'h63;
    for (int k = 1; k <= 4; k++) s ^= (inv << k) | (inv >> (8 - k));
    return s;
  endfunction

  function automatic logic [31:0] subw_ref(input logic [31:0] x);
    return {sbox_ref(x[31:24]), sbox_ref(x[23:16]), sbox_ref(x[15:8]), sbox_ref(x[7:0])};
  endfunction

  function automatic void model_expand(input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int j = 0; j < nk; j++) m_w[j] = key[255-32*j -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = m_w[i-1];
      if (i % nk == 0) begin
        t  = subw_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw_ref(t);
      end
      m_w[i] = m_w[i-nk] ^ t;
    end
  endfunction

  function automatic logic [31:0] inv_mix_ref(input logic [31:0] c);
    logic [7:0] b [4];
    logic [7:0] o [4];
    logic [7:0] coef [4];
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int i = 0; i < 4; i++) b[i] = c[31-8*i -: 8];
    for (int r = 0; r < 4; r++) begin
      o[r] = 8'h00;
      for (int k = 0; k < 4; k++) o[r] ^= gf_mul(coef[(k - r + 4) % 4], b[k]);
    end
    return {o[0], o[1], o[2], o[3]};
  endfunction

  function automatic logic [127:0] model_key(input int r, input logic inv);
    logic [127:0] k = {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]};
    if (InvEn && inv && r > 0 && r < nr) begin
      for (int c = 0; c < 4; c++) k[127-32*c -: 32] = inv_mix_ref(k[127-32*c -: 32]);
    end
    return k;
  endfunction

  task automatic read_check(input int r, input logic inv, input logic exp_valid, input string tag);
    logic [127:0] ek;
    rd_en    = 1'b1;
    rd_round = 4'(r);
    rd_inv   = inv;
    tick();
    rd_en  = 1'b0;
    rd_inv = 1'b0;
    ek = exp_valid ? model_key(r, inv) : 128'h0;
    check({tag, "_valid"}, 128'(obs_valid), 128'(exp_valid));
    check({tag, "_key"}, obs_key, ek);
    last_key = ek;
  endtask

  task automatic start_pulse(input logic [255:0] key, input string tag);
    start_v = 1'b1;
    key_v   = key;
    tick();
    start_v = 1'b0;
    check({tag, "_busy_up"}, 128'(obs_busy), 128'(1));
    check({tag, "_done_low"}, 128'(obs_done), 128'(0));
  endtask

  // Counts busy cycles; optionally fires an ignored start plus a read at busy cycle 10.
  task automatic wait_done(input string tag, input bit inject);
    int cnt = 0;
    while (obs_busy && cnt < 200) begin
      if (inject && cnt == 10) begin
        start_v  = 1'b1;
        key_v    = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
        rd_en    = 1'b1;
        rd_round = 4'd0;
      end
      if (inject && cnt == 11) begin
        start_v = 1'b0;
        rd_en   = 1'b0;
        check({tag, "_rd_busy"}, 128'(obs_valid), 128'(0));
      end
      cnt++;
      tick();
    end
    check({tag, "_busy_len"}, 128'(cnt), 128'(3 * nk + 28));
    check({tag, "_done"}, 128'(obs_done), 128'(1));
  endtask

  logic [255:0] k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  logic [255:0] k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  logic [127:0] r1_128 = 128'ha0fafe1788542cb123a339392a6c7605;
  logic [127:0] rn_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  logic [127:0] r1_256 = 128'h1f352c073b6108d72d9810a30914dff4;
  logic [127:0] rn_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  initial begin
    logic [255:0] fips, nkey;
    logic [127:0] r1_exp, rn_exp, ek;
    int           rr;
    rst_n = 1'b0; sel = 1'b0; start_v = 1'b0; key_v = '0;
    rd_en = 1'b0; rd_round = 4'd0; rd_inv = 1'b0;
    #23;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      check("rst_busy", 128'(obs_busy), 128'(0));
      check("rst_done", 128'(obs_done), 128'(0));
      check("rst_valid", 128'(obs_valid), 128'(0));
      check("rst_key", obs_key, 128'h0);
    end
    rst_n = 1'b1;
    tick();

    for (int s = 0; s < 2; s++) begin
      sel    = (s == 1);
      nk     = (s == 1) ? 8 : 4;
      nr     = nk + 6;
      fips   = (s == 1) ? k256 : k128;
      r1_exp = (s == 1) ? r1_256 : r1_128;
      rn_exp = (s == 1) ? rn_256 : rn_128;
      tick();
      read_check(0, 1'b0, 1'b0, "pre_start");

      model_expand(fips);
      start_pulse(fips, "fips");
      wait_done("fips", 1'b1);
      read_check(1, 1'b0, 1'b1, "r1");
      check("r1_fips", obs_key, r1_exp);
      read_check(nr, 1'b0, 1'b1, "rlast");
      check("rlast_fips", obs_key, rn_exp);
      read_check(0, 1'b0, 1'b1, "r0");
      check("r0_is_key", obs_key, fips[255:128]);
      read_check(nr + 1, 1'b0, 1'b0, "oor");
      read_check(nr, 1'b0, 1'b1, "pre_hold");
      tick();
      check("hold_valid", 128'(obs_valid), 128'(0));
      check("hold_key", obs_key, last_key);
      for (int r = 0; r <= nr; r++) read_check(r, 1'b1, 1'b1, "inv");

      start_pulse(fips, "rst_run");
      repeat (19) tick();
      #2 rst_n = 1'b0;
      #1;
      check("async_busy", 128'(obs_busy), 128'(0));
      check("async_done", 128'(obs_done), 128'(0));
      #3 rst_n = 1'b1;
      tick();
      check("post_rst_done", 128'(obs_done), 128'(0));
      read_check(1, 1'b0, 1'b0, "post_rst_rd");
      start_pulse(fips, "rerun");
      wait_done("rerun", 1'b0);
      read_check(nr, 1'b0, 1'b1, "rerun");
      check("rerun_fips", obs_key, rn_exp);

      repeat (3) begin
        nkey = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
        rr       = $urandom_range(0, nr);
        ek       = model_key(rr, 1'b0);
        rd_en    = 1'b1;
        rd_round = 4'(rr);
        rd_inv   = 1'b0;
        start_v  = 1'b1;
        key_v    = nkey;
        tick();
        start_v = 1'b0;
        rd_en   = 1'b0;
        check("sim_valid", 128'(obs_valid), 128'(1));
        check("sim_old_key", obs_key, ek);
        check("sim_done_low", 128'(obs_done), 128'(0));
        model_expand(nkey);
        wait_done("rnd", 1'b0);
        for (int r = 0; r <= nr; r++) read_check(r, 1'($urandom_range(0, 1)), 1'b1, "rnd");
        repeat (4) begin
          rr = $urandom_range(0, 15);
          read_check(rr, 1'($urandom_range(0, 1)), rr <= nr, "rnd_any");
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
